// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with per-register pending-write scoreboard
// Ports:
//   clk                    rising-edge clock for all state
//   rst                    asynchronous, active-low reset
//   rd_addr  [NUM_RD*AW]   read addresses, port k at [k*AW +: AW]
//   rd_data  [NUM_RD*DATA_W] registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy  [NUM_RD]      registered busy flag of the register read on port k
//   wr_en/wr_addr/wr_data  writeback port; a write also clears the busy bit
//   alloc_en/alloc_addr    marks a destination register as pending
//   any_busy               OR of all scoreboard bits
// Build option: define REGFILE_BYPASS_EN for write-through forwarding of the
// same-edge write data and post-update busy bit onto the read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic                     any_busy
);
    logic [DATA_W-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_nxt;
    logic                     wr_ok;
    logic                     alloc_ok;
    logic [AW-1:0]            ra;
    logic                     zero;
    logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
    logic [NUM_RD-1:0]        rd_busy_nxt;

    // Clear is applied before set so a same-cycle alloc of the written
    // register leaves it pending for the newer producer.
    always_comb begin
        wr_ok    = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
        alloc_ok = alloc_en && !(ZERO_REG != 0 && alloc_addr == '0);
        busy_nxt = busy;
        if (wr_en) busy_nxt[wr_addr] = 1'b0;
        if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
    end

    always_comb begin
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        ra          = '0;
        zero        = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra   = rd_addr[k*AW +: AW];
            zero = ZERO_REG != 0 && ra == '0;
`ifdef REGFILE_BYPASS_EN
            rd_data_nxt[k*DATA_W +: DATA_W] = zero ? '0 : (wr_ok && wr_addr == ra) ? wr_data : regs[ra];
            rd_busy_nxt[k] = busy_nxt[ra];
`else
            rd_data_nxt[k*DATA_W +: DATA_W] = zero ? '0 : regs[ra];
            rd_busy_nxt[k] = busy[ra];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(i);
            busy    <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            busy    <= busy_nxt;
            rd_data <= rd_data_nxt;
            rd_busy <= rd_busy_nxt;
        end
    end

    assign any_busy = |busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp in two configurations
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BY = 1'b1;
`else
    localparam bit BY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en = 1'b0;
    logic [4:0]  a_wr_addr = '0;
    logic [31:0] a_wr_data = '0;
    logic        a_alloc_en = 1'b0;
    logic [4:0]  a_alloc_addr = '0;
    logic        a_any;

    logic [11:0] b_rd_addr = '0;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic        b_alloc_en = 1'b0;
    logic [3:0]  b_alloc_addr = '0;
    logic        b_any;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .any_busy(a_any)
    );

    regfile_mp #(.DATA_W(16), .DEPTH(16), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .any_busy(b_any)
    );

    typedef struct {
        bit              sel;
        int              id;
        logic [2:0]      m;
        logic [2:0][31:0] d;
        logic [2:0]      b;
        logic            any;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input int id, input string what, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL step %0d %s: got %h want %h", id, what, got, want);
        end
    endtask

    initial begin
        exp_t e;
        logic [2:0][31:0] gd;
        logic [2:0] gb;
        logic ga;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                gd = e.sel ? {16'h0, b_rd_data[47:32], 16'h0, b_rd_data[31:16], 16'h0, b_rd_data[15:0]}
                           : {32'h0, a_rd_data};
                gb = e.sel ? b_rd_busy : {1'b0, a_rd_busy};
                ga = e.sel ? b_any : a_any;
                for (int k = 0; k < 3; k++) begin
                    if (e.m[k]) begin
                        chk(e.id, $sformatf("rd_data[%0d]", k), gd[k], e.d[k]);
                        chk(e.id, $sformatf("rd_busy[%0d]", k), {31'h0, gb[k]}, {31'h0, e.b[k]});
                    end
                end
                chk(e.id, "any_busy", {31'h0, ga}, {31'h0, e.any});
            end
        end
    end

    task automatic a_cyc(input int id, input logic [4:0] r0, r1, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic al, input logic [4:0] aa,
                         input logic [31:0] e0, e1, input logic [1:0] eb, input logic ea);
        exp_t e;
        @(negedge clk);
        #1;
        a_rd_addr = {r1, r0};
        a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
        a_alloc_en = al; a_alloc_addr = aa;
        e.sel = 1'b0; e.id = id; e.m = 3'b011; e.d = {32'h0, e1, e0}; e.b = {1'b0, eb}; e.any = ea;
        q.push_back(e);
    endtask

    task automatic b_cyc(input int id, input logic [3:0] r0, r1, r2, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd, input logic al, input logic [3:0] aa,
                         input logic [15:0] e0, e1, e2, input logic [2:0] eb, input logic ea);
        exp_t e;
        @(negedge clk);
        #1;
        b_rd_addr = {r2, r1, r0};
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
        b_alloc_en = al; b_alloc_addr = aa;
        e.sel = 1'b1; e.id = id; e.m = 3'b111;
        e.d = {16'h0, e2, 16'h0, e1, 16'h0, e0}; e.b = eb; e.any = ea;
        q.push_back(e);
    endtask

    task automatic mid_reset(input int id);
        @(negedge clk);
        #1;
        a_rd_addr = {5'd4, 5'd4}; a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h4444;
        b_rd_addr = {4'd4, 4'd4, 4'd4}; b_wr_en = 1'b1; b_wr_addr = 4'd4; b_wr_data = 16'h4444;
        #2 rst = 1'b0;
        #1;
        chk(id, "a rd_data in reset", a_rd_data[31:0] | a_rd_data[63:32], 32'h0);
        chk(id, "a rd_busy in reset", {30'h0, a_rd_busy}, 32'h0);
        chk(id, "a any_busy in reset", {31'h0, a_any}, 32'h0);
        chk(id, "b rd_data in reset", {16'h0, b_rd_data[15:0] | b_rd_data[31:16] | b_rd_data[47:32]}, 32'h0);
        chk(id, "b rd_busy in reset", {29'h0, b_rd_busy}, 32'h0);
        chk(id, "b any_busy in reset", {31'h0, b_any}, 32'h0);
        @(negedge clk);
        #1;
        a_wr_en = 1'b0; a_alloc_en = 1'b0; b_wr_en = 1'b0; b_alloc_en = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        chk(0, "a rd_data at reset", a_rd_data[31:0] | a_rd_data[63:32], 32'h0);
        chk(0, "a any_busy at reset", {31'h0, a_any}, 32'h0);
        chk(0, "b rd_busy at reset", {29'h0, b_rd_busy}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;

        a_cyc(1, 0, 5, 0, 0, 0, 0, 0, 32'h0, 32'h5, 2'b00, 0);
        a_cyc(2, 3, 5, 1, 3, 32'hDEADBEEF, 0, 0, BY ? 32'hDEADBEEF : 32'h3, 32'h5, 2'b00, 0);
        a_cyc(3, 3, 3, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        a_cyc(4, 0, 0, 1, 0, 32'h1234, 0, 0, 32'h0, 32'h0, 2'b00, 0);
        a_cyc(5, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 2'b00, 0);
        a_cyc(6, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0);
        a_cyc(7, 7, 7, 0, 0, 0, 1, 7, 32'h7, 32'h7, BY ? 2'b11 : 2'b00, 1);
        a_cyc(8, 7, 8, 1, 7, 32'h77, 0, 0, BY ? 32'h77 : 32'h7, 32'h8, BY ? 2'b00 : 2'b01, 0);
        a_cyc(9, 7, 7, 0, 0, 0, 0, 0, 32'h77, 32'h77, 2'b00, 0);
        a_cyc(10, 9, 9, 1, 9, 32'h99, 1, 9, BY ? 32'h99 : 32'h9, BY ? 32'h99 : 32'h9, BY ? 2'b11 : 2'b00, 1);
        a_cyc(11, 9, 9, 0, 0, 0, 0, 0, 32'h99, 32'h99, 2'b11, 1);
        a_cyc(12, 9, 10, 1, 9, 32'hAAAA, 1, 10, BY ? 32'hAAAA : 32'h99, 32'hA, BY ? 2'b10 : 2'b01, 1);
        a_cyc(13, 9, 10, 0, 0, 0, 0, 0, 32'hAAAA, 32'hA, 2'b10, 1);
        a_cyc(14, 9, 10, 1, 10, 32'h5, 0, 0, 32'hAAAA, BY ? 32'h5 : 32'hA, BY ? 2'b00 : 2'b10, 0);
        a_cyc(15, 9, 12, 0, 0, 0, 1, 12, 32'hAAAA, 32'hC, BY ? 2'b10 : 2'b00, 1);

        b_cyc(20, 0, 5, 15, 0, 0, 0, 0, 0, 16'h0, 16'h5, 16'hF, 3'b000, 0);
        b_cyc(21, 0, 0, 1, 1, 0, 16'h1234, 0, 0, BY ? 16'h1234 : 16'h0, BY ? 16'h1234 : 16'h0, 16'h1, 3'b000, 0);
        b_cyc(22, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h1234, 16'h1234, 3'b000, 0);
        b_cyc(23, 0, 1, 2, 0, 0, 0, 1, 0, 16'h1234, 16'h1, 16'h2, BY ? 3'b001 : 3'b000, 1);
        b_cyc(24, 0, 1, 2, 0, 0, 0, 0, 0, 16'h1234, 16'h1, 16'h2, 3'b001, 1);
        b_cyc(25, 0, 1, 2, 1, 0, 16'hBEEF, 0, 0, BY ? 16'hBEEF : 16'h1234, 16'h1, 16'h2, BY ? 3'b000 : 3'b001, 0);
        b_cyc(26, 3, 4, 0, 0, 0, 0, 1, 3, 16'h3, 16'h4, 16'hBEEF, BY ? 3'b001 : 3'b000, 1);

        mid_reset(30);

        a_cyc(31, 4, 12, 0, 0, 0, 0, 0, 32'h4, 32'hC, 2'b00, 0);
        a_cyc(32, 3, 9, 0, 0, 0, 0, 0, 32'h3, 32'h9, 2'b00, 0);
        b_cyc(33, 4, 0, 13, 0, 0, 0, 0, 0, 16'h4, 16'h0, 16'hD, 3'b000, 0);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with a per-register pending-write scoreboard.
- Successor to the single-instance 32x32 register file in the processor datapath.
- Sits between decode (read addresses, destination allocation) and writeback (write port).
- Registered reads, hardwired zero register, busy tracking so decode can stall on RAW hazards.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers; power of two, >= 2
NUM_RD, 2, number of read ports, 1..4
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary
AW, $clog2(DEPTH), address width (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
rd_addr  input  NUM_RD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  output  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  registered busy flag of the register read on port k
wr_en  input  1  writeback strobe
wr_addr  input  AW  writeback register index
wr_data  input  DATA_W  writeback data
alloc_en  input  1  mark alloc_addr pending (instruction issued with that destination)
alloc_addr  input  AW  destination register being allocated
any_busy  output  1  OR of all scoreboard bits (combinational from state)

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - reg[i] = i, zero-extended or truncated to DATA_W.
  - All scoreboard bits = 0; rd_data = 0; rd_busy = 0; any_busy = 0.
  - Reset asserted mid-operation discards any in-flight write, allocation or read.
- Write:
  - On rising edge with wr_en = 1, reg[wr_addr] <= wr_data.
  - If ZERO_REG = 1 and wr_addr = 0, the write is dropped.
- Read, latency 1 cycle:
  - At each rising edge, rd_data[k] <= reg[rd_addr[k]] for every port, every cycle; no read enable.
  - If ZERO_REG = 1 and rd_addr[k] = 0, rd_data[k] <= 0.
  - Several ports reading the same address all return the same value.
- Scoreboard, one bit per register, updated at the rising edge:
  - alloc_en sets busy[alloc_addr]; wr_en clears busy[wr_addr].
  - Same address allocated and written in the same cycle: set wins (new producer supersedes old).
  - Different addresses: both updates apply.
  - ZERO_REG = 1: busy[0] is never set.
  - Alloc of an already-busy register keeps it busy; write to a non-busy register leaves it clear. Neither is an error.
- rd_busy[k] <= busy[rd_addr[k]] as seen by the read-data path (see Optional Feature), so data and flag are always consistent.
- any_busy is updated from the post-edge scoreboard state.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined, write-through forwarding:
  - If wr_en = 1 and wr_addr = rd_addr[k] (and not the zero register), rd_data[k] <= wr_data in that same edge.
  - rd_busy[k] <= the post-update busy bit: 0, unless alloc_en hits the same address in that cycle.
- Not defined:
  - rd_data[k] returns the pre-write register value.
  - rd_busy[k] returns the pre-update busy bit.
  - The new value is visible one cycle later.
- Port list identical in both builds.

Test Plan:
1. Release reset, read addrs 0/5 on ports 0/1 -> next cycle rd_data = 0x0 / 0x5, rd_busy = 0/0, any_busy = 0.
2. wr_en = 1, wr_addr = 3, wr_data = 0xDEADBEEF while rd_addr[0] = 3 -> with REGFILE_BYPASS_EN rd_data[0] = 0xDEADBEEF next cycle; without it 0x3 next cycle, then 0xDEADBEEF the cycle after.
3. Write 0x1234 to reg 0 with ZERO_REG = 1, then read 0 -> rd_data = 0, rd_busy = 0; with ZERO_REG = 0 -> rd_data = 0x1234.
4. alloc_en reg 7 -> any_busy = 1 and rd_busy for addr 7 = 1; wr_en reg 7 with 0x77 -> busy cleared, any_busy = 0, read returns 0x77.
5. Same cycle alloc_en and wr_en on reg 9 -> reg 9 = written data, busy[9] = 1, any_busy = 1.
6. Assert rst low mid-cycle during wr_en to reg 4 -> rd_data = 0 immediately, reg 4 reads 0x4 after release, all busy flags 0; repeat with DATA_W = 16, DEPTH = 16, NUM_RD = 3.
